// File: rtl/object_buffer_reader.sv
// rtl/object_buffer_reader.sv - host-loaded object buffer broadcast to raster units one object per task round
module object_buffer_reader #(
    parameter int OBJ_WIDTH  = 96,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  buf_clear,
    input  logic                  wr_en,
    input  logic [OBJ_WIDTH-1:0]  wr_data,
    output logic                  wr_ready,
    input  logic                  frame_start,
    input  logic                  next_task,
    output logic [OBJ_WIDTH-1:0]  obj_data,
    output logic                  obj_valid,
    output logic [ADDR_WIDTH-1:0] obj_index,
    output logic                  read_end,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_LOW, WAIT_HIGH, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   rd_idx_q, rd_idx_d;
    logic                  read_end_q, read_end_d;
    logic                  obj_valid_q;
    logic [OBJ_WIDTH-1:0]  obj_data_q;
    logic [ADDR_WIDTH-1:0] obj_index_q;
    logic [OBJ_WIDTH-1:0]  mem [DEPTH];

    logic                  ctrl_ok;
    logic                  clear_fire;
    logic                  wr_fire;
    logic                  start_fire;
    logic                  last_accepted;
    logic [ADDR_WIDTH:0]   count_eff;

    // Host controls only act while no frame is in flight; a same-cycle clear beats a write and precedes a start.
    assign clear_fire    = ctrl_ok & buf_clear;
    assign wr_fire       = wr_en & wr_ready & ~buf_clear;
    assign start_fire    = ctrl_ok & frame_start;
    assign count_eff     = clear_fire ? '0 : count_q;
    assign last_accepted = (state_q == WAIT_LOW) && !next_task && (rd_idx_q == count_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_fire) begin
                    state_d = (count_eff == '0) ? DONE : FETCH;
                end
            end
            FETCH:     state_d = ISSUE;
            ISSUE:     state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!next_task) begin
                    state_d = (rd_idx_q == count_q) ? DONE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (next_task) begin
                    state_d = FETCH;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_ok   = (state_q == IDLE) || (state_q == DONE);
        busy      = !ctrl_ok;
        wr_ready  = ctrl_ok && (count_q != DEPTH_CNT);
        obj_valid = obj_valid_q;
        obj_data  = obj_data_q;
        obj_index = obj_index_q;
        read_end  = read_end_q;
    end

    always_comb begin
        count_d = count_q;
        if (clear_fire) begin
            count_d = '0;
        end else if (wr_fire) begin
            count_d = count_q + 1'b1;
        end

        rd_idx_d = rd_idx_q;
        if (start_fire) begin
            rd_idx_d = '0;
        end else if (state_q == ISSUE) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end

        read_end_d = read_end_q;
        if (start_fire) begin
            read_end_d = (count_eff == '0);
        end else if (clear_fire) begin
            read_end_d = 1'b0;
        end else if (last_accepted) begin
            read_end_d = 1'b1;
        end
    end

    // The RAM read lands directly in the broadcast register so obj_data is valid in the obj_valid cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            rd_idx_q    <= '0;
            read_end_q  <= 1'b0;
            obj_valid_q <= 1'b0;
            obj_data_q  <= '0;
            obj_index_q <= '0;
        end else begin
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            read_end_q  <= read_end_d;
            obj_valid_q <= (state_q == FETCH);
            if (state_q == FETCH) begin
                obj_data_q  <= mem[rd_idx_q[ADDR_WIDTH-1:0]];
                obj_index_q <= rd_idx_q[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[count_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_object_buffer_reader.sv
// tb/tb_object_buffer_reader.sv - scoreboard bench for object_buffer_reader
module tb_object_buffer_reader;
    localparam int OW    = 96;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          buf_clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [OW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          frame_start = 1'b0;
    logic          next_task = 1'b1;
    logic [OW-1:0] obj_data;
    logic          obj_valid;
    logic [AW-1:0] obj_index;
    logic          read_end;
    logic          busy;

    object_buffer_reader #(.OBJ_WIDTH(OW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .buf_clear(buf_clear),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .frame_start(frame_start), .next_task(next_task),
        .obj_data(obj_data), .obj_valid(obj_valid), .obj_index(obj_index),
        .read_end(read_end), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            idx;
        logic [OW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [OW-1:0] model_mem[$];
    int            valid_seen     = 0;
    int            last_valid_cyc = -1;

    function automatic void check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endfunction

    function automatic logic [OW-1:0] rand_obj();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops the expected object whenever the DUT broadcasts one.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            check("obj_valid_during_reset", obj_valid, 0);
        end else if (obj_valid) begin
            valid_seen++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_obj_valid actual_index=%0d expected=none", obj_index);
            end else begin
                e = exp_q.pop_front();
                check("obj_data", obj_data, e.data);
                check("obj_index", obj_index, e.idx);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_obj_data"}, obj_data, 0);
        check({tag, "_obj_valid"}, obj_valid, 0);
        check({tag, "_obj_index"}, obj_index, 0);
        check({tag, "_read_end"}, read_end, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wr_ready"}, wr_ready, 1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        model_mem.delete();
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        next_task = 1'b1;
        tick(1);
    endtask

    task automatic write_obj(input logic [OW-1:0] d);
        check("wr_ready_before_write", wr_ready, (model_mem.size() < DEPTH));
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
        if (model_mem.size() < DEPTH) model_mem.push_back(d);
    endtask

    task automatic start_frame(output int t0);
        t0 = cyc;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int i = 0; i < model_mem.size(); i++) begin
            exp_t e;
            e.idx  = i;
            e.data = model_mem[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid(input int prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(1);
            if (valid_seen > prev) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL obj_valid_timeout actual=none expected=pulse");
        end
    endtask

    // Units accept (next_task drops), then finish (next_task rises).
    task automatic advance(input bit last);
        int prev;
        int rise;
        bit ok;
        tick($urandom_range(0, 2));
        next_task = 1'b0;
        prev = valid_seen;
        tick($urandom_range(1, 3));
        if (last) begin
            check("read_end_after_last", read_end, 1);
            check("busy_after_last", busy, 0);
            check("no_extra_valid", valid_seen, prev);
            next_task = 1'b1;
        end else begin
            check("read_end_midframe", read_end, 0);
            check("busy_midframe", busy, 1);
            next_task = 1'b1;
            rise = cyc;
            wait_valid(prev, ok);
            if (ok) check("next_task_latency", last_valid_cyc - rise, 2);
        end
    endtask

    task automatic run_frame();
        int n;
        int t0;
        int prev;
        bit ok;
        n    = model_mem.size();
        prev = valid_seen;
        start_frame(t0);
        if (n == 0) begin
            check("empty_read_end", read_end, 1);
            check("empty_busy", busy, 0);
            tick(4);
            check("empty_no_valid", valid_seen, prev);
        end else begin
            wait_valid(prev, ok);
            if (ok) check("frame_start_latency", last_valid_cyc - t0, 2);
            for (int j = 0; j < n; j++) advance(j == n - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        int  prev;
        int  rise;
        bit  ok;
        logic [OW-1:0] a_val;

        // Basic three-object frame
        do_reset();
        check_reset_outputs("reset");
        write_obj(96'hA);
        write_obj(96'hB);
        write_obj(96'hC);
        run_frame();

        // Empty frame after reset
        do_reset();
        run_frame();

        // next_task held high must stall in WAIT_LOW
        do_reset();
        for (int i = 0; i < 3; i++) write_obj(rand_obj());
        prev = valid_seen;
        start_frame(t0);
        wait_valid(prev, ok);
        prev = valid_seen;
        tick(20);
        check("stall_no_issue", valid_seen, prev);
        check("stall_busy", busy, 1);
        next_task = 1'b0;
        tick(1);
        next_task = 1'b1;
        rise = cyc;
        wait_valid(prev, ok);
        if (ok) check("stall_release_latency", last_valid_cyc - rise, 2);
        advance(1'b0);
        advance(1'b1);

        // Full buffer, overflow write dropped, 256-object traversal
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_obj(rand_obj());
        check("full_wr_ready", wr_ready, 0);
        write_obj(rand_obj());
        run_frame();
        check("full_last_index", obj_index, DEPTH - 1);

        // Controls ignored while busy; replay proves count unchanged
        do_reset();
        for (int i = 0; i < 4; i++) write_obj(rand_obj());
        prev = valid_seen;
        start_frame(t0);
        wait_valid(prev, ok);
        advance(1'b0);
        next_task = 1'b0;
        prev = valid_seen;
        tick(2);
        check("busy_wr_ready", wr_ready, 0);
        wr_en = 1'b1; wr_data = rand_obj(); tick(1); wr_en = 1'b0;
        buf_clear = 1'b1; tick(1); buf_clear = 1'b0;
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        check("ignored_busy", busy, 1);
        check("ignored_read_end", read_end, 0);
        next_task = 1'b1;
        rise = cyc;
        wait_valid(prev, ok);
        if (ok) check("ignored_latency", last_valid_cyc - rise, 2);
        advance(1'b0);
        advance(1'b1);
        run_frame();
        buf_clear = 1'b1;
        tick(1);
        buf_clear = 1'b0;
        model_mem.delete();
        check("clear_read_end", read_end, 0);
        check("clear_wr_ready", wr_ready, 1);
        run_frame();

        // Asynchronous reset in WAIT_HIGH of object 1 of 3
        do_reset();
        a_val = rand_obj() | 96'h1;
        write_obj(a_val);
        write_obj(rand_obj());
        write_obj(rand_obj());
        prev = valid_seen;
        start_frame(t0);
        wait_valid(prev, ok);
        check("pre_reset_obj_data", obj_data, a_val);
        next_task = 1'b0;
        tick(2);
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        model_mem.delete();
        exp_q.delete();
        #1 check_reset_outputs("async_reset");
        tick(1);
        reset = 1'b0;
        next_task = 1'b1;
        tick(1);
        run_frame();

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                do_reset();
            end else begin
                buf_clear = 1'b1;
                tick(1);
                buf_clear = 1'b0;
                model_mem.delete();
            end
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) write_obj(rand_obj());
            run_frame();
            if (r == 3) run_frame();
        end

        tick(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/object_buffer_reader.md
Name: object_buffer_reader

Overview:
- Object buffer that sits directly upstream of the task dispatcher: the host loads per-frame objects (triangle descriptors) into an on-chip buffer.
- On frame start it broadcasts objects one at a time to the UNITS parallel raster units.
- It advances to the next object on the dispatcher's next_task level.
- It raises read_end once the last object has been issued and accepted, so the dispatcher can declare the frame's tasks complete.

Parameters:
- OBJ_WIDTH, 96, bits per object descriptor.
- DEPTH, 256, object buffer entries (power of two).
- ADDR_WIDTH, $clog2(DEPTH), buffer index width.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- buf_clear  in  1  pulse; empties the buffer (object count to 0). Honoured only in IDLE/DONE.
- wr_en  in  1  write strobe; accepted only when wr_ready=1.
- wr_data  in  OBJ_WIDTH  object descriptor to append.
- wr_ready  out  1  high in IDLE/DONE when count<DEPTH.
- frame_start  in  1  pulse; begins traversal. Honoured only in IDLE/DONE.
- next_task  in  1  from task dispatcher: registered AND of all unit completes (level).
- obj_data  out  OBJ_WIDTH  current object broadcast to units; held stable between issues.
- obj_valid  out  1  one-cycle pulse; units latch obj_data and go busy.
- obj_index  out  ADDR_WIDTH  index of the object in obj_data.
- read_end  out  1  level; no objects remain for this frame.
- busy  out  1  high in FETCH/ISSUE/WAIT_LOW/WAIT_HIGH.

Behaviour:
- Reset values: state=IDLE, count=0, rd_idx=0, obj_data=0, obj_valid=0, obj_index=0, read_end=0, busy=0, wr_ready=1. Buffer RAM contents are not reset.
- Storage: synchronous single-read RAM, 1-cycle read latency. A write stores to entry [count], then count increments.
- count width is ADDR_WIDTH+1, so count==DEPTH is representable. When count==DEPTH, wr_ready=0.
- A wr_en while wr_ready=0 is dropped: no state change, no error flag.
- buf_clear sets count=0 and read_end=0. If buf_clear and wr_en occur in the same cycle, the clear wins and the write is dropped.
- frame_start with buf_clear in the same cycle: the clear is applied first, giving an empty frame.
- States:
  - IDLE / DONE --frame_start--> if count==0: DONE with read_end=1 on the next edge (empty frame). Otherwise FETCH with rd_idx=0 and read_end cleared.
  - FETCH: RAM address = rd_idx. Next state is ISSUE.
  - ISSUE: obj_data <= RAM output, obj_index <= rd_idx, obj_valid=1 for exactly this cycle, rd_idx <= rd_idx+1. Next state is WAIT_LOW.
  - WAIT_LOW: wait for next_task==0, meaning the units have accepted the task and gone busy. Then:
    - if rd_idx==count: DONE, read_end=1 from the next cycle;
    - else WAIT_HIGH.
  - WAIT_HIGH: wait for next_task==1, meaning all units are finished. Then FETCH.
- The first object of a frame is issued without waiting on next_task: units are idle at frame start.
- Object-to-object latency: the next obj_valid comes 2 cycles after next_task is sampled high in WAIT_HIGH.
- frame_start to first obj_valid: 2 cycles.
- Handshake rule: an advance requires a full low-then-high cycle of next_task. A next_task that stays high and never drops stalls the block in WAIT_LOW, with no second issue.
- read_end stays high in DONE until the next honoured frame_start or buf_clear.
- Writes, frame_start and buf_clear received while busy=1 are ignored.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). obj_valid must not pulse during or after reset. The stored objects and count are lost.

Test Plan:
- Reset, write 3 objects (0xA, 0xB, 0xC), frame_start → obj_valid 2 cycles later with obj_data=0xA, obj_index=0. Drive next_task 0 then 1 twice → 0xB, then 0xC. Drop next_task → read_end=1, busy=0.
- Empty frame: after reset, frame_start with count=0 → read_end=1 one cycle later, obj_valid never asserted.
- Stall: after the first issue, hold next_task=1 for 20 cycles → no second obj_valid. Then drop it and raise it → the second object issues exactly 2 cycles after the rise.
- Full buffer: write DEPTH=256 objects → wr_ready=0 after the 256th write. A 257th wr_en is dropped and count stays 256. Traversal then issues 256 pulses, with obj_index ending at 255.
- Ignored controls: while busy, pulse wr_en, buf_clear and frame_start → count and traversal are unchanged. In DONE, pulse buf_clear → read_end=0 and wr_ready=1.
- Asynchronous reset asserted in WAIT_HIGH of object 1 of 3 → outputs are zero immediately. A subsequent frame_start with no writes → read_end=1 (empty frame).
